// File: rtl/food_spawner.sv
// Food position generator: samples LFSR coordinates, range-checks them and scans the snake body until a free cell is found.
// Optional bounded retry with SPAWN_FAIL reporting is enabled by defining FOOD_RETRY_LIMIT_EN.
module food_spawner #(
  parameter int unsigned X_W   = 8,
  parameter int unsigned Y_W   = 7,
  parameter int unsigned X_MAX = 160,
  parameter int unsigned Y_MAX = 106,
  parameter int unsigned LEN_W = 8
`ifdef FOOD_RETRY_LIMIT_EN
  ,
  parameter int unsigned MAX_RETRY = 15
`endif
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SPAWN_REQ,
  input  logic [X_W-1:0]   RAND_X,
  input  logic [Y_W-1:0]   RAND_Y,
  output logic             RAND_CE,
  input  logic [LEN_W-1:0] SNAKE_LEN,
  output logic [LEN_W-1:0] SEG_ADDR,
  input  logic [X_W-1:0]   SEG_X,
  input  logic [Y_W-1:0]   SEG_Y,
  output logic [X_W-1:0]   FOOD_X,
  output logic [Y_W-1:0]   FOOD_Y,
  output logic             FOOD_VALID,
  output logic             BUSY,
`ifdef FOOD_RETRY_LIMIT_EN
  output logic             SPAWN_FAIL,
`endif
  output logic             SPAWN_DONE
);

  typedef enum logic [2:0] {IDLE, SAMPLE, ADDR, CMP, DONE} state_t;

  state_t           state;
  logic [X_W-1:0]   cand_x;
  logic [Y_W-1:0]   cand_y;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] len_q;
  logic             cand_legal;
  logic             seg_hit;
  logic             publish;

  assign cand_legal = (32'(RAND_X) < X_MAX) && (32'(RAND_Y) < Y_MAX);
  assign seg_hit    = (SEG_X == cand_x) && (SEG_Y == cand_y);

`ifdef FOOD_RETRY_LIMIT_EN
  logic [3:0] retry_cnt;
  assign publish = !SPAWN_FAIL;
`else
  assign publish = 1'b1;
`endif

  // Outputs are registered: each is set on the transition into the state that owns it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      cand_x     <= '0;
      cand_y     <= '0;
      idx        <= '0;
      len_q      <= '0;
      RAND_CE    <= 1'b0;
      SEG_ADDR   <= '0;
      FOOD_X     <= '0;
      FOOD_Y     <= '0;
      FOOD_VALID <= 1'b0;
      BUSY       <= 1'b0;
      SPAWN_DONE <= 1'b0;
`ifdef FOOD_RETRY_LIMIT_EN
      retry_cnt  <= '0;
      SPAWN_FAIL <= 1'b0;
`endif
    end else begin
      RAND_CE    <= 1'b0;
      SPAWN_DONE <= 1'b0;
`ifdef FOOD_RETRY_LIMIT_EN
      SPAWN_FAIL <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (SPAWN_REQ) begin
            FOOD_VALID <= 1'b0;
            BUSY       <= 1'b1;
            RAND_CE    <= 1'b1;
            state      <= SAMPLE;
`ifdef FOOD_RETRY_LIMIT_EN
            retry_cnt  <= '0;
`endif
          end
        end
        SAMPLE: begin
          cand_x <= RAND_X;
          cand_y <= RAND_Y;
          if (!cand_legal) begin
            RAND_CE <= 1'b1;
          end else if (SNAKE_LEN == '0) begin
            SPAWN_DONE <= 1'b1;
            state      <= DONE;
          end else begin
            idx      <= '0;
            SEG_ADDR <= '0;
            len_q    <= SNAKE_LEN;
            state    <= ADDR;
          end
        end
        ADDR: state <= CMP;
        CMP: begin
          if (seg_hit) begin
`ifdef FOOD_RETRY_LIMIT_EN
            if (retry_cnt == 4'(MAX_RETRY)) begin
              SPAWN_DONE <= 1'b1;
              SPAWN_FAIL <= 1'b1;
              state      <= DONE;
            end else begin
              retry_cnt <= retry_cnt + 4'd1;
              RAND_CE   <= 1'b1;
              state     <= SAMPLE;
            end
`else
            RAND_CE <= 1'b1;
            state   <= SAMPLE;
`endif
          end else if (idx == len_q - LEN_W'(1)) begin
            SPAWN_DONE <= 1'b1;
            state      <= DONE;
          end else begin
            idx      <= idx + LEN_W'(1);
            SEG_ADDR <= idx + LEN_W'(1);
            state    <= ADDR;
          end
        end
        DONE: begin
          if (publish) begin
            FOOD_X     <= cand_x;
            FOOD_Y     <= cand_y;
            FOOD_VALID <= 1'b1;
          end
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_food_spawner.sv
// Directed scoreboard bench for food_spawner with a behavioural LFSR stand-in and a 1-cycle-latency segment memory.
module tb_food_spawner;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       SPAWN_REQ;
  logic [7:0] RAND_X;
  logic [6:0] RAND_Y;
  logic       RAND_CE;
  logic [7:0] SNAKE_LEN;
  logic [7:0] SEG_ADDR;
  logic [7:0] SEG_X;
  logic [6:0] SEG_Y;
  logic [7:0] FOOD_X;
  logic [6:0] FOOD_Y;
  logic       FOOD_VALID;
  logic       BUSY;
  logic       SPAWN_DONE;
`ifdef FOOD_RETRY_LIMIT_EN
  logic       SPAWN_FAIL;
`endif

  food_spawner #(.X_W(8)
`ifdef FOOD_RETRY_LIMIT_EN
    , .MAX_RETRY(2)
`endif
  ) dut (
    .CLK(CLK), .RESET(RESET), .SPAWN_REQ(SPAWN_REQ), .RAND_X(RAND_X), .RAND_Y(RAND_Y),
    .RAND_CE(RAND_CE), .SNAKE_LEN(SNAKE_LEN), .SEG_ADDR(SEG_ADDR), .SEG_X(SEG_X),
    .SEG_Y(SEG_Y), .FOOD_X(FOOD_X), .FOOD_Y(FOOD_Y), .FOOD_VALID(FOOD_VALID), .BUSY(BUSY),
`ifdef FOOD_RETRY_LIMIT_EN
    .SPAWN_FAIL(SPAWN_FAIL),
`endif
    .SPAWN_DONE(SPAWN_DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic       valid;
    int         lat;
    int         ce;
    logic       fail;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         ce_cnt = 0;
  int         ce_base = 0;
  int         ridx;
  logic [7:0] tbl_x[16];
  logic [6:0] tbl_y[16];
  logic [7:0] mem_x[256];
  logic [6:0] mem_y[256];

  // LFSR stand-in: the candidate sequence steps once per RAND_CE cycle
  always @(posedge CLK) if (RAND_CE === 1'b1) ce_cnt <= ce_cnt + 1;
  assign ridx   = (ce_cnt - ce_base > 15) ? 15 : ce_cnt - ce_base;
  assign RAND_X = tbl_x[ridx];
  assign RAND_Y = tbl_y[ridx];

  always @(posedge CLK) begin
    SEG_X <= mem_x[SEG_ADDR];
    SEG_Y <= mem_y[SEG_ADDR];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_body(input int n, input logic [7:0] x0, input logic [6:0] y0, input logic [7:0] dx);
    for (int i = 0; i < 256; i++) begin
      mem_x[i] = 8'd255;
      mem_y[i] = 7'd127;
    end
    for (int i = 0; i < n; i++) begin
      mem_x[i] = x0 + 8'(i) * dx;
      mem_y[i] = y0;
    end
    SNAKE_LEN = 8'(n);
  endtask

  task automatic run_spawn(input logic [7:0] ex, input logic [6:0] ey, input logic ev,
                           input int elat, input int ece, input logic ef, input logic poke);
    exp_t e;
    int   cyc;
    @(negedge CLK);
    ce_base = ce_cnt;
    sb.push_back('{x: ex, y: ey, valid: ev, lat: elat, ce: ece, fail: ef});
    SPAWN_REQ = 1'b1;
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
      SPAWN_REQ = poke;
    end while (SPAWN_DONE !== 1'b1 && cyc < 300);
    chk("spawn_done_seen", 32'(SPAWN_DONE), 32'd1);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("latency", 32'(cyc + 1), 32'(e.lat));
      chk("rand_ce_pulses", 32'(ce_cnt - ce_base), 32'(e.ce));
`ifdef FOOD_RETRY_LIMIT_EN
      chk("spawn_fail", 32'(SPAWN_FAIL), 32'(e.fail));
`endif
      @(negedge CLK);
      SPAWN_REQ = 1'b0;
      chk("food_x", 32'(FOOD_X), 32'(e.x));
      chk("food_y", 32'(FOOD_Y), 32'(e.y));
      chk("food_valid", 32'(FOOD_VALID), 32'(e.valid));
      chk("busy_after", 32'(BUSY), 32'd0);
      chk("done_one_pulse", 32'(SPAWN_DONE), 32'd0);
      if (poke) begin
        repeat (3) @(negedge CLK);
        chk("ignored_req_busy", 32'(BUSY), 32'd0);
        chk("ignored_req_ce", 32'(ce_cnt - ce_base), 32'(e.ce));
      end
    end
  endtask

  initial begin
    RESET = 1'b1;
    SPAWN_REQ = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tbl_x[i] = 8'd0;
      tbl_y[i] = 7'd0;
    end
    set_body(0, 8'd0, 7'd0, 8'd0);
    repeat (2) @(negedge CLK);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_valid", 32'(FOOD_VALID), 32'd0);
    chk("rst_ce", 32'(RAND_CE), 32'd0);
    chk("rst_done", 32'(SPAWN_DONE), 32'd0);
    chk("rst_food", 32'({FOOD_X, 1'b0, FOOD_Y}), 32'd0);
    chk("rst_seg_addr", 32'(SEG_ADDR), 32'd0);
    RESET = 1'b0;

    // Empty snake: legal first candidate is published straight away
    tbl_x[0] = 8'd10; tbl_y[0] = 7'd20;
    run_spawn(8'd10, 7'd20, 1'b1, 3, 1, 1'b0, 1'b0);

    // Reset during the first compare cycle of a 3-segment scan
    set_body(3, 8'd1, 7'd1, 8'd1);
    tbl_x[0] = 8'd5; tbl_y[0] = 7'd5;
    @(negedge CLK);
    ce_base = ce_cnt;
    SPAWN_REQ = 1'b1;
    @(negedge CLK);
    SPAWN_REQ = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("midscan_busy", 32'(BUSY), 32'd0);
    chk("midscan_valid", 32'(FOOD_VALID), 32'd0);
    chk("midscan_food", 32'({FOOD_X, 1'b0, FOOD_Y}), 32'd0);
    chk("midscan_done_ce", 32'({SPAWN_DONE, RAND_CE}), 32'd0);
    chk("midscan_seg_addr", 32'(SEG_ADDR), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;

    // Three segments, no hit: full scan then publish; address holds at last segment
    run_spawn(8'd5, 7'd5, 1'b1, 9, 1, 1'b0, 1'b0);
    chk("seg_addr_hold", 32'(SEG_ADDR), 32'd2);

    // Hit on the second segment forces one resample
    set_body(2, 8'd5, 7'd5, 8'd1);
    tbl_x[0] = 8'd6;  tbl_y[0] = 7'd5;
    tbl_x[1] = 8'd40; tbl_y[1] = 7'd30;
    run_spawn(8'd40, 7'd30, 1'b1, 12, 2, 1'b0, 1'b0);

    // Out-of-range Y rejected without a scan; requests while busy are ignored
    set_body(3, 8'd1, 7'd1, 8'd1);
    tbl_x[0] = 8'd7; tbl_y[0] = 7'd110;
    tbl_x[1] = 8'd7; tbl_y[1] = 7'd50;
    run_spawn(8'd7, 7'd50, 1'b1, 10, 2, 1'b0, 1'b1);

    // Range boundaries: X=200 and X=X_MAX rejected, (X_MAX-1, Y_MAX-1) accepted
    set_body(0, 8'd0, 7'd0, 8'd0);
    tbl_x[0] = 8'd200; tbl_y[0] = 7'd5;
    tbl_x[1] = 8'd160; tbl_y[1] = 7'd5;
    tbl_x[2] = 8'd159; tbl_y[2] = 7'd105;
    run_spawn(8'd159, 7'd105, 1'b1, 5, 3, 1'b0, 1'b0);

`ifdef FOOD_RETRY_LIMIT_EN
    // Every candidate hits the body: third match gives up and keeps the old food
    set_body(1, 8'd9, 7'd9, 8'd0);
    for (int i = 0; i < 16; i++) begin
      tbl_x[i] = 8'd9;
      tbl_y[i] = 7'd9;
    end
    run_spawn(8'd159, 7'd105, 1'b0, 11, 3, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
